// File: rtl/fpu_issue_if.sv
// Handshake bundle around fpu_issue: decode request, FPU issue/result,
// register-file writeback and status. The block itself uses the slave view,
// the surrounding pipeline (or a bench) uses the master view.
interface fpu_issue_if #(
    parameter int RD_W = 5
);
    // decode request
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [2:0]      req_subop;
    logic [31:0]     req_a;
    logic [31:0]     req_b;
    logic [RD_W-1:0] req_rd;

    // FPU side
    logic            fpu_in_valid;
    logic [2:0]      fpu_operator;
    logic [2:0]      fpu_subop;
    logic [31:0]     fpu_a;
    logic [31:0]     fpu_b;
    logic            fpu_result_valid;
    logic [31:0]     fpu_c;

    // writeback and status
    logic            wb_valid;
    logic [RD_W-1:0] wb_rd;
    logic            wb_int;
    logic [31:0]     wb_data;
    logic            busy;
    logic            err_timeout;
    logic            err_illegal;

    modport slave (
        input  req_valid, req_op, req_subop, req_a, req_b, req_rd,
        input  fpu_result_valid, fpu_c,
        output req_ready, fpu_in_valid, fpu_operator, fpu_subop, fpu_a, fpu_b,
        output wb_valid, wb_rd, wb_int, wb_data, busy, err_timeout, err_illegal
    );

    modport master (
        output req_valid, req_op, req_subop, req_a, req_b, req_rd,
        output fpu_result_valid, fpu_c,
        input  req_ready, fpu_in_valid, fpu_operator, fpu_subop, fpu_a, fpu_b,
        input  wb_valid, wb_rd, wb_int, wb_data, busy, err_timeout, err_illegal
    );
endinterface

// File: rtl/fpu_issue.sv
// Issue/completion sequencer in front of the FPU dispatcher.
// Takes one operation from decode, fires a single-cycle start pulse to the
// FPU while holding operator/operands steady, and turns the FPU result pulse
// (or a timeout / illegal opcode) into a one-cycle register-file writeback.
// Operator and operands only move on acceptance because the FPU clears its
// per-operator valid keyed on the operator it currently sees.
module fpu_issue #(
    parameter int TIMEOUT = 256,
    parameter int RD_W    = 5
) (
    input  logic       aclk,
    input  logic       aresetn,
    fpu_issue_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       OP_CMP   = 3'd5;
    localparam logic [2:0]       OP_ILL   = 3'd7;
    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    // opcode 7 has no FPU operator behind it
    function automatic logic is_illegal_op(input logic [2:0] op);
        return (op == OP_ILL);
    endfunction

    // only comparisons produce an integer-register result
    function automatic logic writes_int_rf(input logic [2:0] op);
        return (op == OP_CMP);
    endfunction

    state_t          state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]      op_r;
    logic [2:0]      subop_r;
    logic [31:0]     a_r;
    logic [31:0]     b_r;
    logic [RD_W-1:0] rd_r;
    logic            fpu_in_valid_r;
    logic            req_ready_r;
    logic            busy_r;
    logic            wb_valid_r;
    logic            wb_int_r;
    logic [31:0]     wb_data_r;
    logic            err_timeout_r;
    logic            err_illegal_r;

    // Sequencer: state, holding registers, writeback and sticky flags
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r        <= ST_IDLE;
            cnt_r          <= '0;
            op_r           <= 3'd0;
            subop_r        <= 3'd0;
            a_r            <= 32'd0;
            b_r            <= 32'd0;
            rd_r           <= '0;
            fpu_in_valid_r <= 1'b0;
            req_ready_r    <= 1'b1;
            busy_r         <= 1'b0;
            wb_valid_r     <= 1'b0;
            wb_int_r       <= 1'b0;
            wb_data_r      <= 32'd0;
            err_timeout_r  <= 1'b0;
            err_illegal_r  <= 1'b0;
        end else begin
            // strobes are single-cycle unless re-asserted below
            fpu_in_valid_r <= 1'b0;
            wb_valid_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        rd_r        <= bus.req_rd;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (is_illegal_op(bus.req_op)) begin
                            // FPU-side registers stay untouched
                            state_r <= ST_ERR;
                        end else begin
                            op_r           <= bus.req_op;
                            subop_r        <= bus.req_subop;
                            a_r            <= bus.req_a;
                            b_r            <= bus.req_b;
                            fpu_in_valid_r <= 1'b1;
                            state_r        <= ST_ISSUE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // start pulse is visible this cycle; a result now is ignored
                    cnt_r   <= '0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.fpu_result_valid) begin
                        // a result always beats a coincident timeout
                        wb_data_r   <= bus.fpu_c;
                        wb_int_r    <= writes_int_rf(op_r);
                        wb_valid_r  <= 1'b1;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        wb_data_r     <= QNAN;
                        wb_int_r      <= writes_int_rf(op_r);
                        wb_valid_r    <= 1'b1;
                        err_timeout_r <= 1'b1;
                        req_ready_r   <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        state_r <= ST_WAIT;
                    end
                end
                ST_ERR: begin
                    // illegal op writes a quiet NaN to the FP file
                    wb_data_r     <= QNAN;
                    wb_int_r      <= 1'b0;
                    wb_valid_r    <= 1'b1;
                    err_illegal_r <= 1'b1;
                    req_ready_r   <= 1'b1;
                    busy_r        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = req_ready_r;
    assign bus.busy         = busy_r;
    assign bus.fpu_in_valid = fpu_in_valid_r;
    assign bus.fpu_operator = op_r;
    assign bus.fpu_subop    = subop_r;
    assign bus.fpu_a        = a_r;
    assign bus.fpu_b        = b_r;
    assign bus.wb_valid     = wb_valid_r;
    assign bus.wb_rd        = rd_r;
    assign bus.wb_int       = wb_int_r;
    assign bus.wb_data      = wb_data_r;
    assign bus.err_timeout  = err_timeout_r;
    assign bus.err_illegal  = err_illegal_r;

endmodule

// File: tb/tb_fpu_issue.sv
// Directed bench for fpu_issue (TIMEOUT=16). Inputs are driven and outputs
// sampled 1 time unit after each rising edge; the FPU is played by hand
// inside each scenario task.
module tb_fpu_issue;

    logic aclk;
    logic aresetn;
    int   n_checks;
    int   n_errors;

    fpu_issue_if #(.RD_W(5)) bus ();

    fpu_issue #(.TIMEOUT(16), .RD_W(5)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus.slave)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [2:0] subop,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_subop = subop;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_rd    = rd;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
        n_checks++; if (bus.fpu_in_valid !== 1'b0) begin n_errors++; $display("FAIL reset_fpu_in_valid: got %b expected 0", bus.fpu_in_valid); end
        n_checks++; if ({bus.fpu_operator, bus.fpu_subop, bus.fpu_a, bus.fpu_b} !== 70'd0) begin n_errors++; $display("FAIL reset_fpu_data: got %h expected 0", {bus.fpu_operator, bus.fpu_subop, bus.fpu_a, bus.fpu_b}); end
        n_checks++; if ({bus.wb_valid, bus.wb_int, bus.wb_rd, bus.wb_data} !== 39'd0) begin n_errors++; $display("FAIL reset_wb: got %h expected 0", {bus.wb_valid, bus.wb_int, bus.wb_rd, bus.wb_data}); end
        n_checks++; if ({bus.err_timeout, bus.err_illegal} !== 2'b00) begin n_errors++; $display("FAIL reset_err: got %b expected 00", {bus.err_timeout, bus.err_illegal}); end
        aresetn = 1'b1;
        tick();
        n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_idle_ready: got %b expected 1", bus.req_ready); end
    endtask

    task automatic test_add();
        int pulses;
        int early_wb;
        int op_moved;
        drive_req(3'd1, 3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd7);
        tick();                                   // ISSUE cycle
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd4;                     // decode moves on; holds must not follow
        bus.req_a     = 32'hDEAD_BEEF;
        pulses   = (bus.fpu_in_valid === 1'b1) ? 1 : 0;
        early_wb = 0;
        op_moved = 0;
        n_checks++; if (bus.fpu_operator !== 3'd1) begin n_errors++; $display("FAIL add_operator: got %0d expected 1", bus.fpu_operator); end
        n_checks++; if ({bus.fpu_a, bus.fpu_b} !== {32'h3F80_0000, 32'h4000_0000}) begin n_errors++; $display("FAIL add_operands: got %h expected 3f80000040000000", {bus.fpu_a, bus.fpu_b}); end
        n_checks++; if ({bus.busy, bus.req_ready} !== 2'b10) begin n_errors++; $display("FAIL add_busy_ready: got %b expected 10", {bus.busy, bus.req_ready}); end
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.fpu_in_valid === 1'b1) pulses++;
            if (bus.wb_valid === 1'b1) early_wb++;
            if (bus.fpu_operator !== 3'd1 || bus.fpu_a !== 32'h3F80_0000) op_moved++;
        end
        bus.fpu_result_valid = 1'b1;              // result in ISSUE+8
        bus.fpu_c            = 32'h4040_0000;
        tick();
        bus.fpu_result_valid = 1'b0;
        bus.fpu_c            = 32'd0;
        n_checks++; if (pulses !== 1) begin n_errors++; $display("FAIL add_issue_pulses: got %0d expected 1", pulses); end
        n_checks++; if (early_wb !== 0) begin n_errors++; $display("FAIL add_early_wb: got %0d expected 0", early_wb); end
        n_checks++; if (op_moved !== 0) begin n_errors++; $display("FAIL add_hold: got %0d moved cycles expected 0", op_moved); end
        n_checks++; if (bus.wb_valid !== 1'b1) begin n_errors++; $display("FAIL add_wb_valid: got %b expected 1", bus.wb_valid); end
        n_checks++; if (bus.wb_data !== 32'h4040_0000) begin n_errors++; $display("FAIL add_wb_data: got %h expected 40400000", bus.wb_data); end
        n_checks++; if ({bus.wb_int, bus.wb_rd} !== {1'b0, 5'd7}) begin n_errors++; $display("FAIL add_wb_int_rd: got %b/%0d expected 0/7", bus.wb_int, bus.wb_rd); end
        n_checks++; if ({bus.busy, bus.req_ready} !== 2'b01) begin n_errors++; $display("FAIL add_back_idle: got %b expected 01", {bus.busy, bus.req_ready}); end
        tick();
        n_checks++; if (bus.wb_valid !== 1'b0) begin n_errors++; $display("FAIL add_wb_single: got %b expected 0", bus.wb_valid); end
    endtask

    task automatic test_cmp();
        int early_wb;
        drive_req(3'd5, 3'd2, 32'h4120_0000, 32'h4130_0000, 5'd12);
        tick();                                   // ISSUE; a result here is ignored
        bus.req_valid        = 1'b0;
        bus.req_subop        = 3'd6;
        bus.fpu_result_valid = 1'b1;
        bus.fpu_c            = 32'hBAD0_BAD0;
        n_checks++; if ({bus.fpu_in_valid, bus.fpu_subop} !== {1'b1, 3'd2}) begin n_errors++; $display("FAIL cmp_issue: got %b/%0d expected 1/2", bus.fpu_in_valid, bus.fpu_subop); end
        early_wb = 0;
        tick();
        bus.fpu_result_valid = 1'b0;
        if (bus.wb_valid === 1'b1) early_wb++;
        tick();
        if (bus.wb_valid === 1'b1) early_wb++;
        tick();                                   // ISSUE+3
        if (bus.wb_valid === 1'b1) early_wb++;
        n_checks++; if (bus.fpu_subop !== 3'd2) begin n_errors++; $display("FAIL cmp_subop_held: got %0d expected 2", bus.fpu_subop); end
        bus.fpu_result_valid = 1'b1;
        bus.fpu_c            = 32'd1;
        tick();
        bus.fpu_result_valid = 1'b0;
        n_checks++; if (early_wb !== 0) begin n_errors++; $display("FAIL cmp_spurious_wb: got %0d expected 0", early_wb); end
        n_checks++; if ({bus.wb_valid, bus.wb_int} !== 2'b11) begin n_errors++; $display("FAIL cmp_wb_int: got %b expected 11", {bus.wb_valid, bus.wb_int}); end
        n_checks++; if ({bus.wb_data, bus.wb_rd} !== {32'd1, 5'd12}) begin n_errors++; $display("FAIL cmp_wb_data_rd: got %h/%0d expected 1/12", bus.wb_data, bus.wb_rd); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive_req(3'd3, 3'd0, 32'h4000_0000, 32'h4040_0000, 5'd1);
        tick();                                   // MUL ISSUE
        drive_req(3'd4, 3'd0, 32'h4100_0000, 32'h4000_0000, 5'd2);  // DIV waits, req_valid held
        tick();
        n_checks++; if (bus.fpu_operator !== 3'd3) begin n_errors++; $display("FAIL b2b_mul_hold1: got %0d expected 3", bus.fpu_operator); end
        tick();
        n_checks++; if ({bus.fpu_operator, bus.fpu_in_valid} !== {3'd3, 1'b0}) begin n_errors++; $display("FAIL b2b_mul_hold2: got %0d/%b expected 3/0", bus.fpu_operator, bus.fpu_in_valid); end
        bus.fpu_result_valid = 1'b1;
        bus.fpu_c            = 32'h40C0_0000;
        tick();                                   // MUL writeback; DIV accepted at this cycle's end
        bus.fpu_result_valid = 1'b0;
        n_checks++; if ({bus.wb_valid, bus.req_ready} !== 2'b11) begin n_errors++; $display("FAIL b2b_wb1_ready: got %b expected 11", {bus.wb_valid, bus.req_ready}); end
        n_checks++; if ({bus.wb_data, bus.wb_rd} !== {32'h40C0_0000, 5'd1}) begin n_errors++; $display("FAIL b2b_wb1_data: got %h/%0d expected 40c00000/1", bus.wb_data, bus.wb_rd); end
        tick();                                   // DIV ISSUE
        bus.req_valid = 1'b0;
        n_checks++; if ({bus.fpu_in_valid, bus.fpu_operator, bus.wb_valid} !== {1'b1, 3'd4, 1'b0}) begin n_errors++; $display("FAIL b2b_div_issue: got %b/%0d/%b expected 1/4/0", bus.fpu_in_valid, bus.fpu_operator, bus.wb_valid); end
        tick();
        tick();
        n_checks++; if (bus.fpu_b !== 32'h4000_0000 || bus.fpu_operator !== 3'd4) begin n_errors++; $display("FAIL b2b_div_hold: got %0d/%h expected 4/40000000", bus.fpu_operator, bus.fpu_b); end
        bus.fpu_result_valid = 1'b1;
        bus.fpu_c            = 32'h4080_0000;
        tick();
        bus.fpu_result_valid = 1'b0;
        n_checks++; if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, 5'd2, 32'h4080_0000}) begin n_errors++; $display("FAIL b2b_wb2: got %b/%0d/%h expected 1/2/40800000", bus.wb_valid, bus.wb_rd, bus.wb_data); end
        tick();
    endtask

    task automatic test_timeout_race();
        int early_wb;
        drive_req(3'd1, 3'd0, 32'h3F80_0000, 32'h3F80_0000, 5'd4);
        tick();                                   // ISSUE
        bus.req_valid = 1'b0;
        early_wb = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (bus.wb_valid === 1'b1) early_wb++;
        end
        bus.fpu_result_valid = 1'b1;              // same cycle the counter expires
        bus.fpu_c            = 32'h1234_5678;
        tick();
        bus.fpu_result_valid = 1'b0;
        n_checks++; if (early_wb !== 0) begin n_errors++; $display("FAIL race_early_wb: got %0d expected 0", early_wb); end
        n_checks++; if ({bus.wb_valid, bus.wb_data} !== {1'b1, 32'h1234_5678}) begin n_errors++; $display("FAIL race_result_wins: got %b/%h expected 1/12345678", bus.wb_valid, bus.wb_data); end
        n_checks++; if (bus.err_timeout !== 1'b0) begin n_errors++; $display("FAIL race_no_timeout: got %b expected 0", bus.err_timeout); end
        tick();
    endtask

    task automatic test_timeout();
        int early_wb;
        drive_req(3'd2, 3'd0, 32'h4000_0000, 32'h3F80_0000, 5'd9);
        tick();                                   // ISSUE = t+1
        bus.req_valid = 1'b0;
        early_wb = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (bus.wb_valid === 1'b1) early_wb++;
        end
        n_checks++; if (bus.err_timeout !== 1'b0) begin n_errors++; $display("FAIL to_flag_early: got %b expected 0", bus.err_timeout); end
        tick();                                   // t+18
        n_checks++; if (early_wb !== 0) begin n_errors++; $display("FAIL to_early_wb: got %0d expected 0", early_wb); end
        n_checks++; if ({bus.wb_valid, bus.wb_data, bus.wb_rd} !== {1'b1, 32'h7FC0_0000, 5'd9}) begin n_errors++; $display("FAIL to_wb: got %b/%h/%0d expected 1/7fc00000/9", bus.wb_valid, bus.wb_data, bus.wb_rd); end
        n_checks++; if (bus.err_timeout !== 1'b1) begin n_errors++; $display("FAIL to_flag: got %b expected 1", bus.err_timeout); end
        tick();
        drive_req(3'd1, 3'd0, 32'h3F80_0000, 32'h3F80_0000, 5'd3);
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.fpu_result_valid = 1'b1;
        bus.fpu_c            = 32'h4000_0000;
        tick();
        bus.fpu_result_valid = 1'b0;
        n_checks++; if ({bus.wb_valid, bus.wb_data} !== {1'b1, 32'h4000_0000}) begin n_errors++; $display("FAIL to_next_op: got %b/%h expected 1/40000000", bus.wb_valid, bus.wb_data); end
        n_checks++; if (bus.err_timeout !== 1'b1) begin n_errors++; $display("FAIL to_sticky: got %b expected 1", bus.err_timeout); end
        tick();
    endtask

    task automatic test_illegal();
        drive_req(3'd7, 3'd1, 32'h1111_1111, 32'h2222_2222, 5'd3);
        tick();                                   // ERR = t+1
        bus.req_valid = 1'b0;
        n_checks++; if ({bus.fpu_in_valid, bus.wb_valid, bus.busy} !== 3'b001) begin n_errors++; $display("FAIL ill_err_cycle: got %b expected 001", {bus.fpu_in_valid, bus.wb_valid, bus.busy}); end
        tick();                                   // t+2
        n_checks++; if ({bus.wb_valid, bus.wb_data, bus.wb_rd} !== {1'b1, 32'h7FC0_0000, 5'd3}) begin n_errors++; $display("FAIL ill_wb: got %b/%h/%0d expected 1/7fc00000/3", bus.wb_valid, bus.wb_data, bus.wb_rd); end
        n_checks++; if (bus.err_illegal !== 1'b1) begin n_errors++; $display("FAIL ill_flag: got %b expected 1", bus.err_illegal); end
        n_checks++; if ({bus.fpu_operator, bus.fpu_a} !== {3'd1, 32'h3F80_0000}) begin n_errors++; $display("FAIL ill_fpu_untouched: got %0d/%h expected 1/3f800000", bus.fpu_operator, bus.fpu_a); end
        tick();
        n_checks++; if ({bus.wb_valid, bus.err_illegal} !== 2'b01) begin n_errors++; $display("FAIL ill_sticky: got %b expected 01", {bus.wb_valid, bus.err_illegal}); end
    endtask

    task automatic test_reset_mid_wait();
        int stray_wb;
        drive_req(3'd3, 3'd0, 32'h4000_0000, 32'h4000_0000, 5'd8);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();                                   // in WAIT
        aresetn = 1'b0;
        tick();
        n_checks++; if ({bus.busy, bus.fpu_in_valid, bus.wb_valid, bus.err_timeout, bus.err_illegal} !== 5'd0) begin n_errors++; $display("FAIL rmw_ctrl_zero: got %b expected 00000", {bus.busy, bus.fpu_in_valid, bus.wb_valid, bus.err_timeout, bus.err_illegal}); end
        n_checks++; if ({bus.fpu_operator, bus.fpu_a, bus.fpu_b, bus.wb_data, bus.wb_rd} !== 104'd0) begin n_errors++; $display("FAIL rmw_data_zero: got %h expected 0", {bus.fpu_operator, bus.fpu_a, bus.fpu_b, bus.wb_data, bus.wb_rd}); end
        aresetn = 1'b1;
        stray_wb = 0;
        tick();
        tick();
        tick();
        bus.fpu_result_valid = 1'b1;              // late result, lands in IDLE
        bus.fpu_c            = 32'h4080_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.fpu_result_valid = 1'b0;
            if (bus.wb_valid === 1'b1) stray_wb++;
        end
        n_checks++; if (stray_wb !== 0) begin n_errors++; $display("FAIL rmw_late_result: got %0d writebacks expected 0", stray_wb); end
        n_checks++; if ({bus.busy, bus.req_ready} !== 2'b01) begin n_errors++; $display("FAIL rmw_idle: got %b expected 01", {bus.busy, bus.req_ready}); end
        drive_req(3'd1, 3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd5);
        tick();
        bus.req_valid = 1'b0;
        n_checks++; if ({bus.fpu_in_valid, bus.fpu_operator} !== {1'b1, 3'd1}) begin n_errors++; $display("FAIL rmw_next_issue: got %b/%0d expected 1/1", bus.fpu_in_valid, bus.fpu_operator); end
        tick();
        bus.fpu_result_valid = 1'b1;
        bus.fpu_c            = 32'h4040_0000;
        tick();
        bus.fpu_result_valid = 1'b0;
        n_checks++; if ({bus.wb_valid, bus.wb_data, bus.wb_rd} !== {1'b1, 32'h4040_0000, 5'd5}) begin n_errors++; $display("FAIL rmw_next_wb: got %b/%h/%0d expected 1/40400000/5", bus.wb_valid, bus.wb_data, bus.wb_rd); end
        tick();
    endtask

    // Scenario sequence
    initial begin
        n_checks             = 0;
        n_errors             = 0;
        aresetn              = 1'b0;
        bus.req_valid        = 1'b0;
        bus.req_op           = 3'd0;
        bus.req_subop        = 3'd0;
        bus.req_a            = 32'd0;
        bus.req_b            = 32'd0;
        bus.req_rd           = 5'd0;
        bus.fpu_result_valid = 1'b0;
        bus.fpu_c            = 32'd0;
        test_reset();
        test_add();
        test_cmp();
        test_back_to_back();
        test_timeout_race();
        test_timeout();
        test_illegal();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
